mux4_1_rr_collector: RTL and testbench
======================================

// Module: mux4_1_rr_collector
// PURPOSE
//  4:1 stream collector: merges four valid/ready input lanes into one output stream.
//  Round-robin arbitration with one registered output stage.
//  Each output word carries a 2-bit lane tag, out_sel.
//  out_sel uses the same lane encoding as the 1:4 demux select, so the tag can drive a
//  downstream demux directly (00->lane1 ... 11->lane4) to rebuild the four channels.
// PARAMETERS
//  WIDTH  8  data bits per lane and on the output
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   [4:1]    lane k holds a word
//  in_data    in   4*WIDTH  lane k data at bits [k*WIDTH-1 -: WIDTH]
//  in_ready   out  [4:1]    lane k word accepted this cycle (combinational)
//  out_valid  out  1        output register holds a word
//  out_data   out  WIDTH    output word
//  out_sel    out  [2:1]    source lane of out_data: 00=1, 01=2, 10=3, 11=4
//  out_ready  in   1        sink accepts the output word this cycle
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - out_valid=0, out_data=0, out_sel=2'b00, rr pointer=lane1.
//   - in_ready=0 while rst_n=0.
//  FSM: two states.
//   - EMPTY: out_valid=0.
//   - FULL: out_valid=1; hold out_data/out_sel stable until out_ready=1.
//  load_en = ~out_valid | out_ready. This allows a same-cycle drain plus refill, giving full throughput.
//  Grant (combinational):
//   - Search lanes in order ptr, ptr+1, ... with wrap 4->1.
//   - First lane with in_valid=1 wins. At most one grant bit set.
//  in_ready[k] = grant[k] & load_en. Exactly one or zero bits high. Depends combinationally on out_ready.
//  On accept (any in_ready bit high), at the clock edge:
//   - out_data <= lane data; out_sel <= lane-1; out_valid <= 1.
//   - ptr <= granted lane + 1; lane4 wraps to lane1.
//  Drain without accept: out_valid <= 0. out_data/out_sel keep their last values.
//  No in_valid while load_en=1: no change to ptr.
//  Latency: input accept edge -> out_valid next cycle (1 clk).
//  Transitions:
//   - EMPTY->FULL on accept.
//   - FULL->FULL on (out_ready & accept) or ~out_ready.
//   - FULL->EMPTY on out_ready & no accept.
//  Fairness: with all lanes valid and out_ready=1, grants cycle 1,2,3,4,1...
//   Each lane waits at most 3 other grants.
//  Stall: out_ready=0 while FULL -> in_ready=4'b0000, ptr frozen, no input lost.
//  Reset mid-transfer: held word dropped; out_valid=0 immediately (async); ptr=lane1.
//  in_valid deasserted before grant: lane simply skipped; no state retained per lane.
// CONFIGURATION
//  MUX4_FIXED_PRIO_EN defined:
//   - Search always starts at lane1 (lane1 highest ... lane4 lowest).
//   - ptr register removed; starvation of lower lanes is permitted.
//  Undefined (default): round-robin as above.
//  All other behaviour is identical in both builds.
// TESTING
//  T1 reset: rst_n=0 mid-FULL -> out_valid=0, out_sel=00, out_data=0, in_ready=0000 same cycle.
//  T2 single lane: in_valid=0100, lane3 data=8'hA5, out_ready=1
//     -> in_ready=0100; next clk out_valid=1, out_data=A5, out_sel=10.
//  T3 round-robin: in_valid=1111 held, out_ready=1 for 8 clks
//     -> out_sel sequence 00,01,10,11,00,01,10,11; one word per clk.
//  T4 backpressure: FULL with lane2 word, out_ready=0 for 3 clks, in_valid=1111
//     -> in_ready=0000; out_data/out_sel stable; then out_ready=1 -> next grant lane3 (sel 10).
//  T5 drain/refill: FULL, out_ready=1, in_valid=0001 same cycle
//     -> out_valid stays 1, out_sel=00 next clk; then in_valid=0000 -> out_valid=0.
//  T6 MUX4_FIXED_PRIO_EN: in_valid=1111, out_ready=1 for 4 clks
//     -> out_sel=00 every cycle; lanes 2-4 in_ready stay 0.
//  All tests: scoreboard every accepted (lane,data) appears exactly once, in accept order.

Source files
------------

// File: rtl/mux4_1_rr_collector.sv
// 4:1 valid/ready stream collector with round-robin arbitration and one registered output stage.
// Define MUX4_FIXED_PRIO_EN for fixed priority (lane1 highest) with no rr pointer.
module mux4_1_rr_collector #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:1]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [4:1]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:1]         out_sel,
  input  logic               out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic             load_en;
  logic             accept;
  logic [3:0]       valid_v;
  logic [3:0]       grant;
  logic [1:0]       start;
  logic [1:0]       idx;
  logic [1:0]       gidx;
  logic [WIDTH-1:0] gdata;

  assign valid_v   = in_valid;
  assign out_valid = (state == FULL);
  assign load_en   = ~out_valid | out_ready;

  // Search begins at start and wraps; the 2-bit add gives the 4->1 wrap for free.
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if ((grant == '0) && valid_v[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant[i]) gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Gated by rst_n so nothing is accepted while reset is held.
  assign in_ready = rst_n ? (grant & {4{load_en}}) : '0;
  assign accept   = |in_ready;

`ifdef MUX4_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= '0;
    else if (accept) ptr <= gidx + 2'd1;
  end

  assign start = ptr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   if (accept) state_n = FULL;
      FULL:    if (out_ready && !accept) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (accept) begin
      out_data <= gdata;
      out_sel  <= gidx;
    end
  end

endmodule

// File: tb/tb_mux4_1_rr_collector.sv
// Scoreboard bench for mux4_1_rr_collector: a lane-level arbitration model predicts grants,
// accepted words are queued and an independent monitor checks them as they leave.
module tb_mux4_1_rr_collector;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4:1]     in_valid = '0;
  logic [4*W-1:0] in_data = '0;
  logic [4:1]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:1]     out_sel;
  logic           out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           lane;
    logic [W-1:0] data;
  } item_t;
  item_t q[$];

  // Reference model: next lane to search from (1..4) and whether the output holds a word.
  int nxt   = 1;
  bit mfull = 1'b0;

  mux4_1_rr_collector #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*W-1:0] rdata();
    logic [4*W-1:0] d;
    d = {$urandom()};
    return d;
  endfunction

  task automatic cycle(input logic [4:1] v, input logic [4*W-1:0] d, input logic r);
    int           win;
    int           lane;
    logic [4:1]   exp_rdy;
    logic [W-1:0] wd;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #2;
    chk("out_valid", out_valid, mfull);
    win = 0;
    if (!mfull || r) begin
      for (int k = 0; k < 4; k++) begin
        lane = ((nxt - 1 + k) % 4) + 1;
        if (win == 0 && v[lane]) win = lane;
      end
    end
    exp_rdy = '0;
    if (win != 0) exp_rdy[win] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    if (win != 0) begin
      wd = d[win*W-1 -: W];
      q.push_back('{win, wd});
      mfull = 1'b1;
`ifndef MUX4_FIXED_PRIO_EN
      nxt = (win % 4) + 1;
`endif
    end else if (r) begin
      mfull = 1'b0;
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear before any clock edge.
  task automatic reset_now();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_ready", in_ready, 0);
    q.delete();
    mfull    = 1'b0;
    nxt      = 1;
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          it = q.pop_front();
          chk("out_sel", out_sel, it.lane - 1);
          chk("out_data", out_data, it.data);
        end
      end
    end
  end

  initial begin
    logic [4*W-1:0] d;
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #7;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    chk("init_out_sel", out_sel, 0);
    chk("init_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;

    // Single lane: lane3 carries A5.
    d = rdata();
    d[3*W-1 -: W] = 8'hA5;
    cycle(4'b0100, d, 1'b1);
    cycle(4'b0000, '0, 1'b1);

    // Reset while FULL, then round-robin from lane1 with all lanes valid.
    cycle(4'hF, rdata(), 1'b1);
    reset_now();
    repeat (8) cycle(4'hF, rdata(), 1'b1);

    // Backpressure: lane2 word held for 3 clocks, then release.
    reset_now();
    cycle(4'b0010, rdata(), 1'b1);
    repeat (3) cycle(4'hF, rdata(), 1'b0);
    cycle(4'hF, rdata(), 1'b1);

    // Drain plus same-cycle refill, then drain to empty.
    cycle(4'b0001, rdata(), 1'b1);
    cycle(4'b0000, '0, 1'b1);
    cycle(4'b0000, '0, 1'b1);

    // All lanes valid for 4 clocks (fixed-priority build keeps picking lane1).
    repeat (4) cycle(4'hF, rdata(), 1'b1);

    // Randomized traffic with occasional backpressure and a mid-run reset.
    repeat (200) cycle(4'($urandom_range(0, 15)), rdata(), $urandom_range(0, 3) != 0);
    reset_now();
    repeat (200) cycle(4'($urandom_range(0, 15)), rdata(), $urandom_range(0, 2) != 0);

    repeat (3) cycle(4'b0000, '0, 1'b1);
    #2;
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
